// File: rtl/rns_pkg.sv
// Shared RNS definitions for the {7, 8, 9} moduli set: moduli, dynamic range,
// residue widths and the converter state encoding. Also used by the comparator
// and the RNS-to-binary converter.
package rns_pkg;

    // Moduli and dynamic range (7 * 8 * 9).
    localparam int M1    = 7;
    localparam int M2    = 8;
    localparam int M3    = 9;
    localparam int RANGE = M1 * M2 * M3;

    // Residue widths, in the comparator's port order (x1, x2, x3).
    localparam int X1_W = 3;
    localparam int X2_W = 3;
    localparam int X3_W = 4;

    // Serial converter states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } rns_state_t;

endpackage : rns_pkg

// File: rtl/rns_mod_step.sv
// One Horner step of a modular reduction: r_next = (2*r + b) mod M.
// r is always a canonical residue (< M), so 2*r + b < 2*M and a single
// conditional subtract is enough to bring the result back into range.
module rns_mod_step #(
    parameter int M  = 7,
    parameter int RW = 3
) (
    input  logic [RW-1:0] r,
    input  logic          b,
    output logic [RW-1:0] r_next
);

    localparam logic [RW:0] MOD = (RW + 1)'(M);

    logic [RW:0] dbl;
    logic [RW:0] red;

    // Double-and-add, then fold back once if the result reached the modulus.
    always_comb begin
        dbl    = {r, b};
        red    = (dbl >= MOD) ? (dbl - MOD) : dbl;
        r_next = red[RW-1:0];
    end

endmodule : rns_mod_step

// File: rtl/bin_to_rns_9_8_7_serial.sv
// Bit-serial binary-to-RNS converter for moduli {7, 8, 9}.
// An accepted operand is consumed MSB first, one bit per clock, updating the
// three residue accumulators with Horner steps. The result is held on x1/x2/x3
// with out_valid until the consumer takes it; input and output never overlap.
module bin_to_rns_9_8_7_serial
    import rns_pkg::*;
#(
    parameter int W = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [X1_W-1:0] x1,
    output logic [X2_W-1:0] x2,
    output logic [X3_W-1:0] x3
);

    // A counter of at least one bit, so W = 1 still has a legal vector.
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);

    rns_state_t     state_q, state_d;
    logic [W-1:0]    sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [X1_W-1:0] r7_q, r7_d;
    logic [X2_W-1:0] r8_q, r8_d;
    logic [X3_W-1:0] r9_q, r9_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic            bit_in;
    logic [X1_W-1:0] r7_step;
    logic [X2_W-1:0] r8_step;
    logic [X3_W-1:0] r9_step;

    // The bit consumed this cycle is the MSB of the shift register.
    assign bit_in = sr_q[W-1];

    rns_mod_step #(.M(M1), .RW(X1_W)) u_step_7 (
        .r      (r7_q),
        .b      (bit_in),
        .r_next (r7_step)
    );

    rns_mod_step #(.M(M3), .RW(X3_W)) u_step_9 (
        .r      (r9_q),
        .b      (bit_in),
        .r_next (r9_step)
    );

    // Modulus 8 keeps only the low three bits, so its step is a plain shift.
    assign r8_step = {r8_q[X2_W-2:0], bit_in};

    // Next-state and datapath decode for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        // NOTE: every target gets a default first, so no path can infer a latch.
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        r7_d    = r7_q;
        r8_d    = r8_q;
        r9_d    = r9_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    sr_d    = in_data;
                    r7_d    = '0;
                    r8_d    = '0;
                    r9_d    = '0;
                    cnt_d   = CNT_LOAD;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d = sr_q << 1;
                r7_d = r7_step;
                r8_d = r8_step;
                r9_d = r9_step;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake flags are registered copies of the next state.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State, datapath and registered handshake outputs; reset aborts any conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            r7_q        <= '0;
            r8_q        <= '0;
            r9_q        <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            r7_q        <= r7_d;
            r8_q        <= r8_d;
            r9_q        <= r9_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign x1        = r7_q;
    assign x2        = r8_q;
    assign x3        = r9_q;

endmodule : bin_to_rns_9_8_7_serial

// File: tb/tb_bin_to_rns_9_8_7_serial.sv
// Self-checking bench for bin_to_rns_9_8_7_serial: directed cases, a full
// sweep of the dynamic range, randomized operands with random backpressure,
// a mid-conversion reset and a W = 1 instance. Expected residues come from
// plain % arithmetic on the operand.
module tb_bin_to_rns_9_8_7_serial;

    localparam int W = 9;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [2:0]   x1;
    logic [2:0]   x2;
    logic [3:0]   x3;

    logic         in_valid_1 = 1'b0;
    logic         in_ready_1;
    logic [0:0]   in_data_1 = '0;
    logic         out_valid_1;
    logic         out_ready_1 = 1'b0;
    logic [2:0]   x1_1;
    logic [2:0]   x2_1;
    logic [3:0]   x3_1;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int last_hs  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    bin_to_rns_9_8_7_serial #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3)
    );

    bin_to_rns_9_8_7_serial #(.W(1)) dut_w1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_1),
        .in_ready  (in_ready_1),
        .in_data   (in_data_1),
        .out_valid (out_valid_1),
        .out_ready (out_ready_1),
        .x1        (x1_1),
        .x2        (x2_1),
        .x3        (x3_1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full conversion: handshake in, check latency and residues, optionally
    // hold the result under backpressure (pulsing in_valid with 200), then release.
    task automatic convert(input int v, input int hold, input bit pulse, input int exp_gap);
        int guard;
        int k;
        int e1, e2, e3;
        e1 = v % 7;
        e2 = v % 8;
        e3 = v % 9;

        guard = 0;
        while (!in_ready && guard < 30) begin
            tick();
            guard++;
        end
        check("in_ready_idle", in_ready, 1);

        in_valid = 1'b1;
        in_data  = W'(v);
        tick();
        k = cycle;
        in_valid = 1'b0;
        if (exp_gap > 0) check("hs_spacing", k - last_hs, exp_gap);
        last_hs = k;

        guard = 0;
        while (!out_valid && guard < 40) begin
            check("in_ready_busy", in_ready, 0);
            in_data  = W'($urandom);
            in_valid = 1'($urandom_range(0, 1));
            tick();
            guard++;
        end
        in_valid = 1'b0;
        check("latency", guard, W);
        check("x1", x1, e1);
        check("x2", x2, e2);
        check("x3", x3, e3);
        check("no_overlap", in_ready, 0);

        for (int i = 0; i < hold; i++) begin
            if (pulse) begin
                in_valid = 1'b1;
                in_data  = W'(200);
            end
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_x1", x1, e1);
            check("hold_x2", x2, e2);
            check("hold_x3", x3, e3);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
    endtask

    initial begin
        int guard;

        // Reset values while rst_n is low.
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_x1", x1, 0);
        check("rst_x2", x2, 0);
        check("rst_x3", x3, 0);
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);

        // Single operand, then back-to-back operands at full throughput.
        convert(10, 0, 1'b0, 0);
        convert(0, 0, 1'b0, W + 2);
        convert(503, 0, 1'b0, W + 2);
        convert(511, 0, 1'b0, W + 2);

        // Backpressure with an ignored input pulse.
        convert(10, 5, 1'b1, 0);
        check("after_bp_in_ready", in_ready, 1);

        // Reset in the middle of SHIFT for operand 300.
        guard = 0;
        while (!in_ready && guard < 30) begin
            tick();
            guard++;
        end
        in_valid = 1'b1;
        in_data  = W'(300);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_x1", x1, 0);
        check("midrst_x2", x2, 0);
        check("midrst_x3", x3, 0);
        check("midrst_in_ready", in_ready, 0);
        tick();
        check("midrst_hold_valid", out_valid, 0);
        #2 rst_n = 1'b1;
        convert(300, 0, 1'b0, 0);

        // Full sweep of the dynamic range.
        for (int v = 0; v < 504; v++) begin
            convert(v, 0, 1'b0, (v == 0) ? 0 : W + 2);
        end

        // Random operands over the whole input width with random backpressure.
        for (int n = 0; n < 60; n++) begin
            convert(int'($urandom_range(0, 511)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
        end

        // W = 1 instance: single-cycle conversion.
        for (int v = 0; v < 2; v++) begin
            guard = 0;
            while (!in_ready_1 && guard < 10) begin
                tick();
                guard++;
            end
            check("w1_in_ready", in_ready_1, 1);
            in_valid_1 = 1'b1;
            in_data_1  = 1'(v);
            tick();
            in_valid_1 = 1'b0;
            check("w1_busy_valid", out_valid_1, 0);
            check("w1_busy_ready", in_ready_1, 0);
            tick();
            check("w1_out_valid", out_valid_1, 1);
            check("w1_x1", x1_1, v % 7);
            check("w1_x2", x2_1, v % 8);
            check("w1_x3", x3_1, v % 9);
            out_ready_1 = 1'b1;
            tick();
            out_ready_1 = 1'b0;
            check("w1_drop", out_valid_1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_bin_to_rns_9_8_7_serial
